// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: state encoding, requester ids and width helper shared by the arbiter slice
package ram_arbiter_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOCKED_A = 2'd1;
  localparam logic [1:0] ST_LOCKED_B = 2'd2;
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: two requester ports plus the watchdog pulse of the shared-RAM arbiter
interface ram_arbiter_if #(
  parameter int ADDRESS_BITS = 6,
  parameter int DATA_BITS = 8
);
  logic a_req, a_we, a_lock, a_gnt, a_rvalid;
  logic [ADDRESS_BITS-1:0] a_addr;
  logic [DATA_BITS-1:0] a_wdata, a_rdata;
  logic b_req, b_we, b_lock, b_gnt, b_rvalid;
  logic [ADDRESS_BITS-1:0] b_addr;
  logic [DATA_BITS-1:0] b_wdata, b_rdata;
  logic lock_timeout;
  modport master (
    output a_req, a_we, a_lock, a_addr, a_wdata, b_req, b_we, b_lock, b_addr, b_wdata,
    input a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata, lock_timeout
  );
  modport slave (
    input a_req, a_we, a_lock, a_addr, a_wdata, b_req, b_we, b_lock, b_addr, b_wdata,
    output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata, lock_timeout
  );
endinterface

// File: rtl/ram_arbiter_ram.sv
// ram_arbiter_ram: single-port synchronous RAM, registered read-before-write, contents never reset
module ram_arbiter_ram #(
  parameter int ADDRESS_BITS = 6,
  parameter int DATA_BITS = 8
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic [ADDRESS_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0]    data_in,
  output logic [DATA_BITS-1:0]    data_out
);
  logic [DATA_BITS-1:0] mem [0:(1<<ADDRESS_BITS)-1];
  // write when enabled; read port always returns the word held before this edge
  always_ff @(posedge clk) begin
    if (en) mem[addr] <= data_in;
    data_out <= mem[addr];
  end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin two-requester arbiter with lock/watchdog sharing one RAM
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDRESS_BITS = 6,
  parameter int DATA_BITS = 8,
  parameter int LOCK_MAX = 16
) (
  input logic         clk,
  input logic         rst_n,
  ram_arbiter_if.slave bus
);
  localparam int CW = clog2(LOCK_MAX) + 1;
  logic [1:0] state, state_nx;
  logic [CW-1:0] cnt;
  logic last_gnt, resp_valid, resp_owner, timeout;
  logic a_win, a_gnt, b_gnt, owner, own_lock, forced, we;
  logic [ADDRESS_BITS-1:0] addr;
  logic [DATA_BITS-1:0] data_in, data_out;
  // grant selection, lock release decision and RAM drive
  always_comb begin
    a_win = bus.a_req & (!bus.b_req | last_gnt == REQ_B);
    a_gnt = rst_n & (state == ST_LOCKED_A ? bus.a_req : state == ST_LOCKED_B ? 1'b0 : a_win);
    b_gnt = rst_n & (state == ST_LOCKED_B ? bus.b_req : state == ST_LOCKED_A ? 1'b0 : bus.b_req & !a_win);
    owner = state == ST_LOCKED_B ? REQ_B : REQ_A;
    own_lock = owner == REQ_B ? bus.b_lock : bus.a_lock;
    forced = state != ST_IDLE & own_lock & cnt == CW'(LOCK_MAX - 1);
    state_nx = state != ST_IDLE ? (!own_lock | forced ? ST_IDLE : state)
             : a_gnt & bus.a_lock ? ST_LOCKED_A
             : b_gnt & bus.b_lock ? ST_LOCKED_B : ST_IDLE;
    addr = b_gnt ? bus.b_addr : bus.a_addr;
    data_in = b_gnt ? bus.b_wdata : bus.a_wdata;
    we = b_gnt ? bus.b_we : a_gnt & bus.a_we;
  end
  // lock FSM, round-robin history, watchdog counter and read-response tagging
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      last_gnt <= REQ_B;
      cnt <= '0;
      timeout <= 1'b0;
      resp_valid <= 1'b0;
      resp_owner <= REQ_A;
    end else begin
      state <= state_nx;
      last_gnt <= forced ? owner : b_gnt ? REQ_B : a_gnt ? REQ_A : last_gnt;
      cnt <= state == ST_IDLE ? '0 : cnt + CW'(1);
      timeout <= forced;
      resp_valid <= (a_gnt | b_gnt) & !we;
      resp_owner <= b_gnt ? REQ_B : REQ_A;
    end
  end
  ram_arbiter_ram #(.ADDRESS_BITS(ADDRESS_BITS), .DATA_BITS(DATA_BITS)) u_ram (
    .clk(clk), .en(we), .addr(addr), .data_in(data_in), .data_out(data_out)
  );
  assign bus.a_gnt = a_gnt;
  assign bus.b_gnt = b_gnt;
  assign bus.a_rvalid = resp_valid & resp_owner == REQ_A;
  assign bus.b_rvalid = resp_valid & resp_owner == REQ_B;
  assign bus.a_rdata = data_out;
  assign bus.b_rdata = data_out;
  assign bus.lock_timeout = timeout;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed grant vectors with a read-response scoreboard
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;
  typedef struct {
    logic owner;
    logic [7:0] data;
    time t;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [7:0] model [0:63];
  exp_t exp_q [$];
  ram_arbiter_if #(.ADDRESS_BITS(6), .DATA_BITS(8)) bus ();
  ram_arbiter #(.ADDRESS_BITS(6), .DATA_BITS(8), .LOCK_MAX(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic drive_a(input logic req, input logic we, input logic lock, input logic [5:0] addr, input logic [7:0] wdata);
    bus.a_req = req;
    bus.a_we = we;
    bus.a_lock = lock;
    bus.a_addr = addr;
    bus.a_wdata = wdata;
  endtask
  task automatic drive_b(input logic req, input logic we, input logic lock, input logic [5:0] addr, input logic [7:0] wdata);
    bus.b_req = req;
    bus.b_we = we;
    bus.b_lock = lock;
    bus.b_addr = addr;
    bus.b_wdata = wdata;
  endtask
  task automatic step(input string name, input logic ea, input logic eb, input logic et);
    exp_t e;
    @(negedge clk);
    check({name, "_a_gnt"}, bus.a_gnt, ea);
    check({name, "_b_gnt"}, bus.b_gnt, eb);
    check({name, "_lock_timeout"}, bus.lock_timeout, et);
    if (bus.a_gnt) begin
      if (bus.a_we) model[bus.a_addr] = bus.a_wdata;
      else begin
        e.owner = REQ_A; e.data = model[bus.a_addr]; e.t = $time;
        exp_q.push_back(e);
      end
    end
    if (bus.b_gnt) begin
      if (bus.b_we) model[bus.b_addr] = bus.b_wdata;
      else begin
        e.owner = REQ_B; e.data = model[bus.b_addr]; e.t = $time;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic check_quiet(input string name);
    check({name, "_a_gnt"}, bus.a_gnt, 0);
    check({name, "_b_gnt"}, bus.b_gnt, 0);
    check({name, "_a_rvalid"}, bus.a_rvalid, 0);
    check({name, "_b_rvalid"}, bus.b_rvalid, 0);
    check({name, "_lock_timeout"}, bus.lock_timeout, 0);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (bus.a_rvalid && bus.b_rvalid) begin
          checks++;
          failures++;
          $display("FAIL both_rvalid actual=11 expected=one_hot");
        end else if (bus.a_rvalid || bus.b_rvalid) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rvalid actual=a%0b/b%0b expected=none", bus.a_rvalid, bus.b_rvalid);
          end else begin
            e = exp_q.pop_front();
            check("rvalid_owner", bus.b_rvalid, e.owner);
            check("rdata", bus.b_rvalid ? bus.b_rdata : bus.a_rdata, e.data);
            check("read_latency", 32'($time - e.t), 11);
          end
        end else if (exp_q.size() != 0 && $time - exp_q[0].t > 5) begin
          e = exp_q.pop_front();
          checks++;
          failures++;
          $display("FAIL missing_rvalid actual=none expected=owner%0b data=%0h", e.owner, e.data);
        end
      end
    end
  end
  initial begin
    drive_a(1, 1, 0, 3, 8'hA5);
    drive_b(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("t1_wr", 1, 0, 0);
    drive_a(1, 0, 0, 3, 0);
    step("t1_rd", 1, 0, 0);
    drive_a(0, 0, 0, 0, 0);
    drive_b(1, 1, 0, 5, 8'h5B);
    step("pre_b5", 0, 1, 0);
    drive_b(1, 1, 0, 7, 8'h77);
    step("pre_b7", 0, 1, 0);
    drive_a(1, 0, 0, 3, 0);
    drive_b(1, 0, 0, 5, 0);
    step("t2_c0", 1, 0, 0);
    step("t2_c1", 0, 1, 0);
    step("t2_c2", 1, 0, 0);
    step("t2_c3", 0, 1, 0);
    drive_b(0, 0, 0, 0, 0);
    step("t3_pre", 1, 0, 0);
    drive_b(1, 0, 1, 7, 0);
    step("t3_lock_rd", 0, 1, 0);
    drive_b(0, 0, 1, 7, 0);
    step("t3_hold", 0, 0, 0);
    drive_b(1, 1, 0, 7, 8'h78);
    step("t3_wr", 0, 1, 0);
    drive_b(0, 0, 0, 0, 0);
    step("t3_a", 1, 0, 0);
    drive_a(1, 0, 0, 7, 0);
    step("t3_rd7", 1, 0, 0);
    drive_a(1, 0, 1, 3, 0);
    step("t4_lock", 1, 0, 0);
    drive_a(0, 0, 1, 0, 0);
    drive_b(1, 0, 0, 5, 0);
    step("t4_l0", 0, 0, 0);
    step("t4_l1", 0, 0, 0);
    step("t4_l2", 0, 0, 0);
    step("t4_l3", 0, 0, 0);
    drive_a(1, 0, 0, 3, 0);
    step("t4_rel", 0, 1, 1);
    drive_b(0, 0, 0, 0, 0);
    step("t4_after", 1, 0, 0);
    drive_a(0, 0, 0, 0, 0);
    step("t4_idle", 0, 0, 0);
    drive_a(1, 0, 0, 3, 0);
    step("t5_rd", 1, 0, 0);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_quiet("t5_in_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("t5_rd3", 1, 0, 0);
    drive_a(1, 0, 0, 7, 0);
    step("t5_rd7", 1, 0, 0);
    drive_a(1, 0, 1, 3, 0);
    step("t6_lock", 1, 0, 0);
    drive_a(0, 0, 0, 0, 0);
    drive_b(1, 0, 0, 5, 0);
    step("t6_abort", 0, 0, 0);
    step("t6_b", 0, 1, 0);
    drive_b(0, 0, 0, 0, 0);
    step("t6_idle", 0, 0, 0);
    step("t6_idle2", 0, 0, 0);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Two-requester arbiter that shares one single-port synchronous RAM (registered read, read-before-write, no reset on contents) between requester A and requester B.
- Accepts at most one access per cycle and applies round-robin fairness.
- Supports a lock so one requester can hold the RAM for an atomic read-modify-write; a watchdog forcibly releases a lock that is held too long.
- Instantiates the RAM internally and returns registered read data to the requester that issued the read.

Parameters:
ADDRESS_BITS, 6, RAM address width.
DATA_BITS, 8, RAM data width.
LOCK_MAX, 16, maximum consecutive cycles a lock may be held before forced release (>=2).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
a_req  input  1  requester A access request; must stay asserted, with a_we/a_addr/a_wdata stable, until a_gnt.
a_we  input  1  A: 1 = write, 0 = read.
a_lock  input  1  A: request or keep exclusive ownership after this access.
a_addr  input  ADDRESS_BITS  A access address.
a_wdata  input  DATA_BITS  A write data.
a_gnt  output  1  A access accepted this cycle (combinational).
a_rvalid  output  1  A read data valid.
a_rdata  output  DATA_BITS  A read data.
b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for requester B.
lock_timeout  output  1  one-cycle pulse when a lock is forcibly released.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - State IDLE; last_gnt = B, so A wins the first contention.
  - resp_valid = 0, lock counter = 0, lock_timeout = 0.
  - a_gnt/b_gnt forced to 0 and RAM enable forced to 0 while rst_n = 0.
  - RAM contents are retained.
- Grant in state IDLE:
  - Only one request active: that requester is granted.
  - Both active: the requester that is not last_gnt is granted.
  - last_gnt updates on every grant.
  - Never both gnt in the same cycle.
- Grant in state LOCKED_A: only A can be granted; B is held off regardless of b_req. LOCKED_B is symmetric.
- RAM drive:
  - On grant, address = granted addr; RAM enable = granted we; data_in = granted wdata.
  - With no grant, RAM enable = 0.
- State transitions:
  - IDLE -> LOCKED_x: on a grant to x with x_lock = 1.
  - LOCKED_x -> IDLE: on a grant to x with x_lock = 0 (the access completes and the lock is released in the same cycle).
  - LOCKED_x -> IDLE (abort): when x_req = 0 and x_lock = 0.
  - LOCKED_x -> IDLE (forced): when the lock counter reaches LOCK_MAX-1. lock_timeout pulses in the following cycle. last_gnt is set to x, so the other requester gets priority.
- Lock counter:
  - Cleared on entry to LOCKED.
  - Increments every cycle in LOCKED, including cycles with an access.
  - Width is clog2(LOCK_MAX)+1.
- Response path:
  - A read grant in cycle N sets resp_valid and resp_owner (registered) for cycle N+1.
  - x_rvalid = resp_valid & (resp_owner == x) in cycle N+1.
  - Read latency is exactly 1 cycle, which allows back-to-back reads with one response per cycle.
  - Writes produce no rvalid.
  - a_rdata and b_rdata both carry the RAM data_out; they are meaningful only when the matching rvalid is high.
- Read-before-write: a write followed by a read of the same address on consecutive grants returns the new data. A read issued in the same cycle as a write is impossible, because there is one grant per cycle.
- Reset mid-operation: any pending rvalid is dropped, any lock is cleared, and no lock_timeout pulse is issued.

Decomposition:
- Shared package: state encoding (IDLE, LOCKED_A, LOCKED_B), requester ID constants (REQ_A = 0, REQ_B = 1), and a clog2 helper for the lock counter width.
- One natural sub-module: the existing ram, instantiated with ADDRESS_BITS and DATA_BITS passed through.
- Arbitration, lock FSM and response tagging stay in ram_arbiter.

Test Plan:
1. After reset: A writes 0xA5 to addr 3 with B idle -> a_gnt = 1 that cycle. A then reads addr 3 -> a_rvalid = 1 and a_rdata = 0xA5 one cycle after the grant; b_rvalid stays 0.
2. Contention: a_req and b_req held high for 4 cycles, both reading -> grant sequence A, B, A, B. rvalid follows each grant by 1 cycle with the matching owner.
3. Lock RMW: B reads addr 7 with b_lock = 1, then writes addr 7 with b_lock = 0, while a_req is held high throughout -> a_gnt = 0 until the B write is granted; A is granted in the cycle after that.
4. Watchdog with LOCK_MAX = 4: A is granted with a_lock = 1, then a_req = 0 and a_lock = 1 are held -> after 4 LOCKED cycles the state returns to IDLE. lock_timeout pulses for 1 cycle, and a pending b_req is granted in the next cycle.
5. Reset mid-operation: assert rst_n = 0 in the cycle after a read grant -> a_rvalid stays 0 and all outputs are 0. After release, previously written data is still readable.
6. Abort lock: A is granted with a_lock = 1, then a_req = 0 and a_lock = 0 the next cycle -> state returns to IDLE and lock_timeout is never asserted.
